pc_stack: RTL
=============

# pc_stack

Parametrised program counter with a hardware return-address stack, the successor to the 8-bit increment/load counter on the shared processor data bus. Supports increment, absolute load, PC-relative branch, subroutine call and return. An idle cycle holds the current value rather than clearing it. The block drives the shared tri-state `data` bus when enabled and samples it for load, branch and call targets.

## Interface

Parameters:
- `N`, 8: PC and bus width in bits, N ≥ 2.
- `DEPTH`, 4: number of return-stack entries, DEPTH ≥ 1.
- `RESET_VEC`, 0: value loaded into the PC on reset, N bits.

Ports:
- `clk`  input  1: single clock. All state changes on the rising edge.
- `nrst`  input  1: reset, synchronous and active-low.
- `pc_inc`  input  1: increment the PC.
- `pc_load`  input  1: PC takes `data` (absolute jump).
- `pc_branch`  input  1: PC takes PC + `data`, with `data` treated as a signed two's-complement offset.
- `pc_call`  input  1: push PC+1 onto the stack, then PC takes `data`.
- `pc_ret`  input  1: pop the top of the stack into the PC.
- `pc_valid`  input  1: drive the PC onto `data`.
- `data`  inout  N: shared bus. Driven with the PC when `pc_valid`=1, otherwise high-Z.
- `pc_out`  output  N: registered PC, always visible.
- `stack_empty`  output  1: stack depth is 0.
- `stack_full`  output  1: stack depth equals DEPTH.
- `stack_err`  output  1: sticky flag, set on overflow or underflow.

## Operation

- **State:** PC register (N bits), return stack (DEPTH × N), depth counter (width clog2(DEPTH+1)), `stack_err` flag.
- **Reset** (`nrst`=0 at a rising edge), values take effect that edge:
  - PC = RESET_VEC
  - depth = 0, so `stack_empty`=1 and `stack_full`=0
  - `stack_err`=0
  - Stack contents are don't-care.
  - Reset overrides every command, including a reset asserted mid-sequence (for example on a call cycle). No push occurs.
- **Command priority**, highest first. Exactly one command executes per cycle:
  1. `pc_ret`
  2. `pc_call`
  3. `pc_branch`
  4. `pc_load`
  5. `pc_inc`
  6. hold
- **ret:**
  - Depth > 0: PC = stack[depth-1], depth decrements.
  - Depth = 0 (underflow): PC holds, depth holds, `stack_err` is set.
- **call:**
  - Depth < DEPTH: stack[depth] = (PC+1) mod 2^N, depth increments, PC = `data`.
  - Depth = DEPTH (overflow): no push, PC holds, `stack_err` is set.
- **branch:** PC = (PC + sign-extended `data`) mod 2^N. There is no overflow flag.
- **load:** PC = `data`.
- **inc:** PC = (PC+1) mod 2^N. All-ones wraps to 0.
- **hold:** no command asserted. PC and the stack are unchanged.
- **Sticky error:** once set, `stack_err` clears only on reset.
- **Bus readback:** `pc_valid`=1 together with load, branch or call samples the block's own drive.
  - load: PC unchanged.
  - branch: PC doubles mod 2^N.
  - call: PC unchanged and the push still occurs.
- The bus is high-Z whenever `pc_valid`=0, including during reset.

## Timing

- Single-cycle latency: a command sampled at edge k appears on `pc_out` and the flags right after edge k.
- `data` is sampled at the same rising edge as the command and must be stable around it.
- The `data` drive is combinational from `pc_valid` and the PC register, so it reflects the PC from the previous edge.
- Back-to-back call, call, ret, ret on consecutive cycles is legal; each cycle's command uses the state from the previous edge.
- `stack_empty` and `stack_full` are decoded from the registered depth, so they update in the same cycle as the depth counter.
- `stack_err` updates at the edge where the faulting command is sampled.

## Test plan

- **Reset and hold:** RESET_VEC=8'h10, deassert `nrst`, idle 3 cycles -> `pc_out`=8'h10, `stack_empty`=1, `stack_err`=0, `data`=Z.
- **Increment wrap and drive:**
  - Load 8'hFE, then `pc_inc` ×3 -> `pc_out` = FF, 00, 01.
  - With `pc_valid`=1 -> `data` equals `pc_out` each cycle.
- **Branch:**
  - PC=8'h20, branch `data`=8'hFC -> PC=8'h1C.
  - Then branch `data`=8'h7F -> PC=8'h9B.
- **Call/return nesting (DEPTH=4):**
  - From PC=8'h05, call 8'h40, then call 8'h80 -> PC=8'h80, depth 2.
  - ret -> PC=8'h41. ret -> PC=8'h06, `stack_empty`=1.
- **Overflow, underflow and priority:**
  - 5 calls -> 5th leaves PC unchanged, `stack_full`=1, `stack_err`=1.
  - 4 rets then a 5th ret -> PC unchanged, `stack_err` stays 1.
  - All commands asserted together -> only the ret executes.
- **Reset mid-operation:** assert `nrst`=0 on a call cycle with depth 2 -> no push, PC=RESET_VEC, depth 0, `stack_err`=0.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack.
// It drives the shared data bus when pc_valid is high, and it samples the same bus for load, branch and call targets.
module pc_stack #(
  parameter int unsigned N         = 8,
  parameter int unsigned DEPTH     = 4,
  parameter logic [N-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         pc_inc,
  input  logic         pc_load,
  input  logic         pc_branch,
  input  logic         pc_call,
  input  logic         pc_ret,
  input  logic         pc_valid,
  inout  wire logic [N-1:0] data,
  output logic [N-1:0] pc_out,
  output logic         stack_empty,
  output logic         stack_full,
  output logic         stack_err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]  pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [N-1:0]  stack_q [DEPTH];
  logic [N-1:0]  stack_d [DEPTH];
  logic [N-1:0]  pc_plus1;
  logic [N-1:0]  stack_top;
  logic          is_empty, is_full;

  assign is_empty    = (depth_q == '0);
  assign is_full     = (depth_q == DW'(DEPTH));
  assign pc_out      = pc_q;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;
  assign stack_err   = err_q;
  assign data        = pc_valid ? pc_q : 'z;

  always_comb begin
    pc_plus1  = pc_q + ONE;
    stack_top = '0;
    // Entries are selected by comparing against depth, so the index never exceeds the array bounds.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (DW'(i + 1) == depth_q) stack_top = stack_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (pc_ret) begin
      if (!is_empty) begin
        pc_d    = stack_top;
        depth_d = depth_q - DW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (pc_call) begin
      if (!is_full) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (DW'(i) == depth_q) stack_d[i] = pc_plus1;
        end
        depth_d = depth_q + DW'(1);
        pc_d    = data;
      end else begin
        err_d = 1'b1;
      end
    end else if (pc_branch) begin
      // A plain N-bit sum is the same as adding a sign-extended offset modulo 2^N.
      pc_d = pc_q + data;
    end else if (pc_load) begin
      pc_d = data;
    end else if (pc_inc) begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) stack_q <= stack_d;
  end

endmodule
